// File: rtl/mole_hit_judge_if.sv
// Generator-to-judge mole index handshake: the judge raises mole_req and the
// generator answers with a one-cycle mole_valid strobe qualifying mole_idx.
interface mole_hit_judge_if;
   logic       mole_req;
   logic       mole_valid;
   logic [1:0] mole_idx;

   modport master (input mole_req, output mole_valid, output mole_idx);
   modport slave  (output mole_req, input mole_valid, input mole_idx);
endinterface

// File: rtl/mole_hit_judge.sv
// Mole selection consumer and hit judge: lights one mole per round, scores key hits and timeouts.
// Optional macro WHACK_MISS_PENALTY_EN: a wrong-key-only press during SHOW decrements the score.
module mole_hit_judge #(
   parameter int SHOW_CYCLES = 25_000_000,
   parameter int GAP_CYCLES  = 12_500_000,
   parameter int SCORE_W     = 8
) (
   input  logic               clock,
   input  logic               Reset,
   input  logic               enable_i,
   mole_hit_judge_if.slave    mole_bus,
   input  logic [3:0]         keys_i,
   output logic [3:0]         mole_leds_o,
   output logic [SCORE_W-1:0] score_o,
   output logic [SCORE_W-1:0] miss_count_o,
   output logic               hit_pulse_o,
   output logic               miss_pulse_o
);

   localparam int MAX_CYC = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
   localparam int TIMER_W = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;
   localparam logic [TIMER_W-1:0] SHOW_LOAD = TIMER_W'(SHOW_CYCLES - 1);
   localparam logic [TIMER_W-1:0] GAP_LOAD  = TIMER_W'(GAP_CYCLES - 1);
   localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

   typedef enum logic [1:0] {IDLE, REQ, SHOW, GAP} state_e;

   state_e             state_q, state_d;
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic [1:0]         idx_q, idx_d;
   logic [3:0]         keys_q;
   logic [SCORE_W-1:0] score_q, score_d;
   logic [SCORE_W-1:0] miss_q, miss_d;
   logic               hit_q, hit_d;
   logic               missp_q, missp_d;

   logic [3:0] key_edge;
   logic       correct_edge;

   assign key_edge     = keys_i & ~keys_q;
   assign correct_edge = key_edge[idx_q];

`ifdef WHACK_MISS_PENALTY_EN
   logic wrong_edge;
   assign wrong_edge = (key_edge != 4'b0000) && !correct_edge;
`endif

   // keys_q resets high so keys held through reset never look like a fresh press
   always_ff @(posedge clock or posedge Reset) begin
      if (Reset) begin
         state_q <= IDLE;
         timer_q <= '0;
         idx_q   <= '0;
         keys_q  <= 4'b1111;
         score_q <= '0;
         miss_q  <= '0;
         hit_q   <= 1'b0;
         missp_q <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         idx_q   <= idx_d;
         keys_q  <= keys_i;
         score_q <= score_d;
         miss_q  <= miss_d;
         hit_q   <= hit_d;
         missp_q <= missp_d;
      end
   end

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      idx_d   = idx_q;
      score_d = score_q;
      miss_d  = miss_q;
      hit_d   = 1'b0;
      missp_d = 1'b0;
      if (!enable_i) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
               if (mole_bus.mole_valid) begin
                  idx_d   = mole_bus.mole_idx;
                  timer_d = SHOW_LOAD;
                  state_d = SHOW;
               end
            end
            SHOW: begin
               // a correct press beats both a simultaneous wrong press and expiry
               if (correct_edge) begin
                  if (score_q != SCORE_MAX) score_d = score_q + 1'b1;
                  hit_d   = 1'b1;
                  timer_d = GAP_LOAD;
                  state_d = GAP;
               end else begin
`ifdef WHACK_MISS_PENALTY_EN
                  if (wrong_edge && score_q != '0) score_d = score_q - 1'b1;
`endif
                  if (timer_q == '0) begin
                     if (miss_q != SCORE_MAX) miss_d = miss_q + 1'b1;
                     missp_d = 1'b1;
                     timer_d = GAP_LOAD;
                     state_d = GAP;
                  end else begin
                     timer_d = timer_q - 1'b1;
                  end
               end
            end
            GAP: begin
               if (timer_q == '0) state_d = REQ;
               else               timer_d = timer_q - 1'b1;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign mole_bus.mole_req = (state_q == REQ);
   assign mole_leds_o       = (state_q == SHOW) ? (4'b0001 << idx_q) : 4'b0000;
   assign score_o           = score_q;
   assign miss_count_o      = miss_q;
   assign hit_pulse_o       = hit_q;
   assign miss_pulse_o      = missp_q;

endmodule
